// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: state and counter-mode encodings shared by the stopwatch stages
package stopwatch_pkg;
    typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_RUN, ST_PAUSE} state_t;
    localparam logic [1:0] EN_CLEAR = 2'b00;
    localparam logic [1:0] EN_COUNT = 2'b10;
    localparam logic [1:0] EN_HOLD  = 2'b11;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronizes and debounces an active-low key, pulsing once per accepted press
module key_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic Rbutton,
    input  logic i_key,
    output logic o_press
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    logic [1:0]    r_sync;
    logic          r_level;
    logic          r_press;
    logic [CW-1:0] r_cnt;
    logic          w_diff;
    logic          w_accept;
    assign w_diff   = r_sync[1] != r_level;
    assign w_accept = w_diff && (r_cnt == CNT_LAST);
    assign o_press  = r_press;
    always_ff @(posedge clk or negedge Rbutton) begin
        if (!Rbutton) begin
            r_sync  <= 2'b11;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_key};
            r_cnt   <= (w_diff && !w_accept) ? r_cnt + 1'b1 : '0;
            r_level <= w_accept ? r_sync[1] : r_level;
            r_press <= w_accept && !r_sync[1];
        end
    end
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounced run/pause/clear control and tick prescaler driving the BCD counter's en code
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 100,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       Rbutton,
    input  logic       key_ss,
    input  logic       key_clr,
    output logic [1:0] en,
    output logic       tick,
    output logic       running
);
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int DW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_div;
    logic [DW-1:0] w_div_nxt;
    logic [1:0]    r_en;
    logic [1:0]    w_en_nxt;
    logic          r_tick;
    logic          w_tick_nxt;
    logic          r_running;
    logic          w_running_nxt;
    logic          w_ss;
    logic          w_clr;
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_ss (
        .clk     (clk),
        .Rbutton (Rbutton),
        .i_key   (key_ss),
        .o_press (w_ss)
    );
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_clr (
        .clk     (clk),
        .Rbutton (Rbutton),
        .i_key   (key_clr),
        .o_press (w_clr)
    );
    assign en      = r_en;
    assign tick    = r_tick;
    assign running = r_running;
    always_ff @(posedge clk or negedge Rbutton) begin
        if (!Rbutton) begin
            r_state   <= ST_CLEAR;
            r_div     <= '0;
            r_en      <= EN_CLEAR;
            r_tick    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_div     <= w_div_nxt;
            r_en      <= w_en_nxt;
            r_tick    <= w_tick_nxt;
            r_running <= w_running_nxt;
        end
    end
    // clr outranks ss when stopped; in RUN only ss matters
    always_comb begin
        w_state_nxt   = r_state;
        w_div_nxt     = '0;
        w_state_nxt   = (r_state == ST_CLEAR) ? ST_IDLE :
                        (r_state == ST_RUN)   ? (w_ss ? ST_PAUSE : ST_RUN) :
                        w_clr                 ? ST_CLEAR :
                        w_ss                  ? ST_RUN : r_state;
        w_div_nxt     = (r_state == ST_RUN)   ? ((r_div == DIV_LAST) ? '0 : r_div + 1'b1) :
                        (r_state == ST_PAUSE) ? r_div : '0;
        w_tick_nxt    = (w_state_nxt == ST_RUN) && (w_div_nxt == DIV_LAST);
        w_en_nxt      = (w_state_nxt == ST_CLEAR) ? EN_CLEAR : w_tick_nxt ? EN_COUNT : EN_HOLD;
        w_running_nxt = w_state_nxt == ST_RUN;
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed table and sequence checks of stopwatch_ctrl with TICK_DIV=10, DB_CYCLES=4
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;
    typedef struct {
        logic       ss;
        logic       clr;
        int         n;
        logic [1:0] en;
        logic       tick;
        logic       run;
    } vec_t;
    logic       clk;
    logic       Rbutton;
    logic       key_ss;
    logic       key_clr;
    logic [1:0] en;
    logic       tick;
    logic       running;
    int         checks;
    int         failures;
    int         ticks;
    vec_t       tbl[8];
    stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .DB_CYCLES(4)) dut (
        .clk     (clk),
        .Rbutton (Rbutton),
        .key_ss  (key_ss),
        .key_clr (key_clr),
        .en      (en),
        .tick    (tick),
        .running (running)
    );
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic press(input logic s, input logic c);
        if (s) key_ss = 1'b0;
        if (c) key_clr = 1'b0;
        cyc(7);
        key_ss  = 1'b1;
        key_clr = 1'b1;
    endtask
    initial begin
        checks   = 0;
        failures = 0;
        ticks    = 0;
        // bouncing ss (2-cycle runs never reach 4 stable samples), then a stable low
        tbl[0] = '{1'b0, 1'b1, 2, EN_HOLD, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 2, EN_HOLD, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 2, EN_HOLD, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 2, EN_HOLD, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 2, EN_HOLD, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 2, EN_HOLD, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 6, EN_HOLD, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1, EN_HOLD, 1'b0, 1'b1};
        Rbutton = 1'b1;
        key_ss  = 1'b1;
        key_clr = 1'b1;
        #2 Rbutton = 1'b0;
        #1;
        chk("rst_async_en", en, EN_CLEAR);
        chk("rst_async_running", running, 0);
        chk("rst_async_tick", tick, 0);
        cyc(2);
        Rbutton = 1'b1;
        chk("rel_clear_en", en, EN_CLEAR);
        cyc(1);
        chk("rel_idle_en", en, EN_HOLD);
        chk("rel_idle_running", running, 0);
        for (int i = 0; i < 8; i++) begin
            key_ss  = tbl[i].ss;
            key_clr = tbl[i].clr;
            cyc(tbl[i].n);
            chk($sformatf("tbl%0d_en", i), en, tbl[i].en);
            chk($sformatf("tbl%0d_tick", i), tick, tbl[i].tick);
            chk($sformatf("tbl%0d_running", i), running, tbl[i].run);
        end
        // RUN from cycle 1; release ss at 4, press again at 39 to pause with prescaler=5
        for (int c = 1; c <= 45; c++) begin
            if (c > 1) cyc(1);
            chk($sformatf("run%0d_en", c), en, (c % 10 == 0) ? EN_COUNT : EN_HOLD);
            chk($sformatf("run%0d_tick", c), tick, (c % 10 == 0) ? 1 : 0);
            chk($sformatf("run%0d_running", c), running, 1);
            if (en == EN_COUNT) ticks++;
            if (c == 35) chk("ticks_in_35", ticks, 3);
            key_ss = (c >= 4 && c < 39) ? 1'b1 : 1'b0;
        end
        chk("ticks_in_45", ticks, 4);
        cyc(1);
        chk("pause_en", en, EN_HOLD);
        chk("pause_running", running, 0);
        key_ss = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            chk("pause_hold_en", en, EN_HOLD);
            chk("pause_hold_tick", tick, 0);
        end
        press(1'b1, 1'b0);
        chk("resume_running", running, 1);
        chk("resume_en", en, EN_HOLD);
        // resumed at prescaler 5: ticks on RUN cycles 5 and 15; clr pressed meanwhile is ignored
        for (int r = 2; r <= 20; r++) begin
            cyc(1);
            chk($sformatf("resume%0d_en", r), en, (r % 10 == 5) ? EN_COUNT : EN_HOLD);
            chk($sformatf("resume%0d_running", r), running, 1);
            key_clr = (r >= 6 && r < 12) ? 1'b0 : 1'b1;
        end
        press(1'b1, 1'b1);
        chk("both_run_en", en, EN_HOLD);
        chk("both_run_running", running, 0);
        cyc(8);
        chk("both_run_hold_en", en, EN_HOLD);
        press(1'b0, 1'b1);
        chk("clr_pause_en", en, EN_CLEAR);
        chk("clr_pause_running", running, 0);
        cyc(1);
        chk("clr_pause_idle_en", en, EN_HOLD);
        cyc(8);
        press(1'b1, 1'b0);
        chk("idle_ss_running", running, 1);
        cyc(8);
        press(1'b1, 1'b0);
        chk("run_ss_pause_running", running, 0);
        chk("run_ss_pause_en", en, EN_HOLD);
        cyc(8);
        press(1'b1, 1'b1);
        chk("both_pause_en", en, EN_CLEAR);
        cyc(1);
        chk("both_pause_idle_en", en, EN_HOLD);
        chk("both_pause_idle_running", running, 0);
        cyc(8);
        press(1'b1, 1'b0);
        chk("pre_rst_running", running, 1);
        cyc(3);
        #2 Rbutton = 1'b0;
        #1;
        chk("midrun_rst_en", en, EN_CLEAR);
        chk("midrun_rst_running", running, 0);
        chk("midrun_rst_tick", tick, 0);
        cyc(2);
        Rbutton = 1'b1;
        chk("midrun_rel_en", en, EN_CLEAR);
        cyc(1);
        chk("midrun_idle_en", en, EN_HOLD);
        chk("midrun_idle_running", running, 0);
        cyc(2);
        press(1'b1, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) cyc(1);
            chk($sformatf("restart%0d_en", c), en, (c == 10) ? EN_COUNT : EN_HOLD);
            chk($sformatf("restart%0d_tick", c), tick, (c == 10) ? 1 : 0);
            chk($sformatf("restart%0d_running", c), running, 1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
